// File: rtl/chunked_serial_adder.sv
// ============================================================================
//  Module   : chunked_serial_adder
//  Purpose  : Adds two WIDTH-bit operands plus carry-in, CHUNK bits per clock,
//             through a registered inter-chunk carry; start/done handshake.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module chunked_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  generate
    if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("chunked_serial_adder: illegal WIDTH/CHUNK combination");
    end
  endgenerate

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             a_msb;
  logic             b_msb;

  logic             accept;
  logic             last;
  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] res_next;

  assign chunk_sum = {1'b0, a_sh[CHUNK-1:0]}
                   + {1'b0, b_sh[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, carry};

  // Each chunk result enters at the top, so after NCH shifts the first chunk
  // sits in the least-significant position.
  assign res_next = (res_sh >> CHUNK)
                  | (WIDTH'(chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK));

  assign last   = (cnt == LAST);
  assign accept = ready & start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        ready      = 1'b1;
        done       = 1'b1;
        state_next = start ? RUN : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_sh   <= a;
      b_sh   <= b;
      res_sh <= '0;
      carry  <= cin;
      cnt    <= '0;
      a_msb  <= a[WIDTH-1];
      b_msb  <= b[WIDTH-1];
    end else if (state == RUN) begin
      a_sh   <= a_sh >> CHUNK;
      b_sh   <= b_sh >> CHUNK;
      res_sh <= res_next;
      carry  <= chunk_sum[CHUNK];
      cnt    <= cnt + 1'b1;
      if (last) begin
        sum      <= res_next;
        cout     <= chunk_sum[CHUNK];
        overflow <= (a_msb == b_msb) && (res_next[WIDTH-1] != a_msb);
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/chunked_serial_adder.md
Name: chunked_serial_adder

Overview:
- Multi-cycle, parametrised successor to the single-bit full adder.
- Adds two WIDTH-bit operands plus carry-in, CHUNK bits per clock, through a registered inter-chunk carry.
- Uses a start/done handshake so datapaths can trade adder area for latency.
- Sits between operand registers and the result consumer; one addition in flight at a time.

Parameters:
- WIDTH, 16, operand and sum width in bits. Must be ≥1.
- CHUNK, 4, bits added per cycle. 1 ≤ CHUNK ≤ WIDTH, and WIDTH % CHUNK == 0. An illegal combination is an elaboration error.
- NCH (localparam), WIDTH/CHUNK, number of processing cycles.

Ports:
- clk  input  1  sole clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when ready=1.
- a  input  WIDTH  operand A, captured on an accepted start.
- b  input  WIDTH  operand B, captured on an accepted start.
- cin  input  1  carry-in, captured on an accepted start.
- ready  output  1  high in IDLE and DONE; new start accepted.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse: sum/cout/overflow valid.
- sum  output  WIDTH  result, held until the next completion.
- cout  output  1  unsigned carry-out of bit WIDTH-1.
- overflow  output  1  two's-complement overflow flag.

Behaviour:
- Reset (async assert, any state): state=IDLE; ready=1, busy=0, done=0, sum=0, cout=0, overflow=0. Internal shift registers, carry register and chunk counter cleared. Effective from the assertion instant, with no clock needed. First accepted start is at the first clk edge after deassertion with start=1.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1: latch a, b, cin into internal regs; counter=0; go to RUN. IDLE, start=0: stay.
- RUN, each edge:
  - chunk_sum = a_sh[CHUNK-1:0] + b_sh[CHUNK-1:0] + carry_reg, computed CHUNK+1 bits wide.
  - Low CHUNK bits shift into the top of the result shift reg; a_sh and b_sh shift right by CHUNK.
  - carry_reg takes chunk_sum[CHUNK]; counter increments.
- RUN, on the edge where counter==NCH-1:
  - sum takes the completed result; cout takes the final carry.
  - overflow = (a_cap[WIDTH-1]==b_cap[WIDTH-1]) && (sum[WIDTH-1]!=a_cap[WIDTH-1]).
  - done=1; go to DONE.
- DONE: done is high for exactly this one cycle.
  - start=1: capture new operands, go to RUN (back-to-back; throughput NCH+1 cycles per add).
  - start=0: go to IDLE.
  - done deasserts at the next edge in both cases.
- Latency: start accepted at edge E → done high in the cycle after edge E+NCH.
- CHUNK==WIDTH: NCH=1, single RUN cycle.
- start while busy=1: ignored, with no effect on the in-flight operation. Operand inputs are don't-care outside an accepted start.
- sum, cout and overflow change only on completion or reset. They hold the previous result throughout the next RUN.
- No internal arithmetic truncation: carry_reg is exactly 1 bit; chunk adder is CHUNK+1 bits.

Test Plan:
- WIDTH=1, CHUNK=1, all 8 (a,b,cin) combinations → sum/cout match the full-adder truth table, e.g. 1+1+1 → sum=1, cout=1; done exactly 1 edge after each accepted start.
- WIDTH=16, CHUNK=4: a=0x1234, b=0x4321, cin=0 → sum=0x5555, cout=0, overflow=0; done in the cycle after edge E+4; busy high 4 cycles.
- WIDTH=16, CHUNK=4:
  - 0xFFFF+0x0001+0 → sum=0x0000, cout=1, overflow=0.
  - 0x7FFF+0x0001+0 → sum=0x8000, cout=0, overflow=1.
  - 0x0000+0x0000+1 → sum=0x0001.
- start pulsed again with different operands during RUN → ignored; result equals the first operands. start held high in DONE → second add begins immediately and completes NCH+1 cycles after the first done.
- rst asserted mid-RUN (after 2 chunks) → outputs 0, ready=1 immediately, without waiting for clk. A subsequent add of 0x00FF+0x0001 → sum=0x0100 with no residue from the aborted operation.
- WIDTH=16 with CHUNK=16 and CHUNK=1 on random vectors → sum, cout and overflow match the reference a+b+cin; latency is 1 and 16 respectively.
